// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream handshake from the UART receiver plus the register-write bus.
interface uart_cmd_decoder_if;

  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] err_cnt;

  modport slave (
    input  rx_data, rx_rdy,
    output rx_ack, wr_stb, wr_addr, wr_data, err_cnt
  );

  modport master (
    output rx_data, rx_rdy,
    input  rx_ack, wr_stb, wr_addr, wr_data, err_cnt
  );

endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes SYNC/ADDR/DATA/CSUM frames from a UART byte stream into register writes,
// counting bad checksums and inter-byte timeouts.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input  logic             baud_clk,
  input  logic             rst_n,
  uart_cmd_decoder_if.slave bus
);

  localparam int unsigned     TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rx_ack_q, rx_ack_d;
  logic             wr_stb_q, wr_stb_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       err_q, err_d;

  logic       consume;
  logic       err_inc;
  logic [7:0] sum_nx;

  // The ack cycle is blocked because upstream rx_rdy is still high then.
  assign consume = bus.rx_rdy && !rx_ack_q;
  assign sum_nx  = sum_q + bus.rx_data;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sum_d     = sum_q;
    tmr_d     = tmr_q;
    rx_ack_d  = consume;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (consume && bus.rx_data == SYNC) begin
          state_d = ADDR;
          sum_d   = SYNC;
        end
      end
      ADDR, DATA: begin
        if (consume) begin
          if (state_q == ADDR) begin
            addr_d  = bus.rx_data;
            state_d = DATA;
          end else begin
            data_d  = bus.rx_data;
            state_d = CSUM;
          end
          sum_d = sum_nx;
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
          err_inc = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      CSUM: begin
        if (consume) begin
          state_d = IDLE;
          tmr_d   = '0;
          if (sum_nx == 8'h00) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            err_inc = 1'b1;
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
          err_inc = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      sum_q     <= '0;
      tmr_q     <= '0;
      rx_ack_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sum_q     <= sum_d;
      tmr_q     <= tmr_d;
      rx_ack_q  <= rx_ack_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_ack  = rx_ack_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed frame vectors plus timeout, reset and saturation sequences for uart_cmd_decoder.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int unsigned TO = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(.TIMEOUT(TO), .SYNC(8'h55)) dut (
    .baud_clk(clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0, ack_cnt = 0, stb_cnt = 0, b2b_viol = 0;
  logic prev_ack = 1'b0, prev_stb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_ack) ack_cnt++;
    if (bus.wr_stb) stb_cnt++;
    if ((bus.rx_ack && prev_ack) || (bus.wr_stb && prev_stb)) b2b_viol++;
    prev_ack = bus.rx_ack;
    prev_stb = bus.wr_stb;
  end

  int unsigned pass_cnt = 0, total = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic stb_seen);
    bit got;
    got      = 1'b0;
    stb_seen = 1'b0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.rx_ack) begin
        got      = 1'b1;
        stb_seen = bus.wr_stb;
        break;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL ack_wait: no rx_ack within 20 cycles for byte %02h", b);
    end
    // upstream drops rx_rdy one cycle after seeing the ack
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][7:0] f, output logic stb_last);
    logic s;
    for (int i = 3; i >= 0; i--) send_byte(f[i], s);
    stb_last = s;
  endtask

  task automatic fast_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.rx_data = b;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rx_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL fast_ack: no rx_ack within 4 cycles for byte %02h", b);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [3:0][7:0] f;
    logic            stb;
    logic [7:0]      addr;
    logic [7:0]      data;
    logic [7:0]      err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic st;
    int unsigned a0, s0, c0;

    vecs[0] = '{32'h55103C5F, 1'b1, 8'h10, 8'h3C, 8'd0};
    vecs[1] = '{32'h55103C60, 1'b0, 8'h10, 8'h3C, 8'd1};
    vecs[2] = '{32'h550102A8, 1'b1, 8'h01, 8'h02, 8'd1};
    vecs[3] = '{32'h55555501, 1'b1, 8'h55, 8'h55, 8'd1};
    vecs[4] = '{32'h55FFFFAD, 1'b1, 8'hFF, 8'hFF, 8'd1};
    vecs[5] = '{32'h550000AB, 1'b1, 8'h00, 8'h00, 8'd1};

    bus.rx_data = 8'h00;
    bus.rx_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  bus.rx_ack,  0);
    check("rst_stb",  bus.wr_stb,  0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_data", bus.wr_data, 0);
    check("rst_err",  bus.err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      a0 = ack_cnt; s0 = stb_cnt;
      send_frame(vecs[i].f, st);
      settle();
      check($sformatf("v%0d_stb_lat1", i), st, vecs[i].stb);
      check($sformatf("v%0d_addr", i), bus.wr_addr, vecs[i].addr);
      check($sformatf("v%0d_data", i), bus.wr_data, vecs[i].data);
      check($sformatf("v%0d_err", i), bus.err_cnt, vecs[i].err);
      check($sformatf("v%0d_nstb", i), stb_cnt - s0, vecs[i].stb);
      check($sformatf("v%0d_nack", i), ack_cnt - a0, 4);
    end

    // junk bytes before SYNC are acked and dropped silently
    a0 = ack_cnt; s0 = stb_cnt;
    send_byte(8'h00, st);
    send_byte(8'hFF, st);
    send_frame(32'h55103C5F, st);
    settle();
    check("pre_nack", ack_cnt - a0, 6);
    check("pre_nstb", stb_cnt - s0, 1);
    check("pre_addr", bus.wr_addr, 8'h10);
    check("pre_data", bus.wr_data, 8'h3C);
    check("pre_err",  bus.err_cnt, 1);

    // inter-byte timeout drops the partial frame
    send_byte(8'h55, st);
    send_byte(8'h10, st);
    repeat (200) @(posedge clk);
    #1;
    check("to_early_err", bus.err_cnt, 1);
    repeat (100) @(posedge clk);
    #1;
    check("to_err", bus.err_cnt, 2);
    s0 = stb_cnt;
    send_frame(32'h55103C5F, st);
    settle();
    check("to_next_stb", stb_cnt - s0, 1);

    // byte lands on the final timer cycle: consumption wins
    send_byte(8'h55, st);
    repeat (254) @(posedge clk);
    #1;
    check("edge_pre_err", bus.err_cnt, 2);
    send_byte(8'h10, st);
    send_byte(8'h3C, st);
    send_byte(8'h5F, st);
    check("edge_stb", st, 1);
    check("edge_err", bus.err_cnt, 2);

    // one cycle later the timeout wins and the byte is hunted as non-SYNC
    send_byte(8'h55, st);
    repeat (255) @(posedge clk);
    #1;
    check("late_err", bus.err_cnt, 3);
    s0 = stb_cnt;
    send_byte(8'h10, st);
    send_byte(8'h3C, st);
    send_byte(8'h5F, st);
    settle();
    check("late_nstb", stb_cnt - s0, 0);
    send_frame(32'h550102A8, st);
    check("late_recover_stb", st, 1);
    check("late_recover_err", bus.err_cnt, 3);

    // asynchronous reset mid-frame
    send_byte(8'h55, st);
    send_byte(8'h10, st);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_addr", bus.wr_addr, 0);
    check("mrst_data", bus.wr_data, 0);
    check("mrst_err",  bus.err_cnt, 0);
    check("mrst_ack",  bus.rx_ack,  0);
    check("mrst_stb",  bus.wr_stb,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = stb_cnt;
    send_byte(8'h3C, st);
    send_byte(8'h5F, st);
    settle();
    check("mrst_discard_stb", stb_cnt - s0, 0);
    check("mrst_discard_err", bus.err_cnt, 0);
    send_frame(32'h55103C5F, st);
    check("mrst_recover_stb", st, 1);
    check("mrst_recover_addr", bus.wr_addr, 8'h10);

    // 300 bad frames with rx_rdy held high throughout
    a0 = ack_cnt; s0 = stb_cnt; c0 = cyc;
    bus.rx_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      fast_byte(8'h55);
      fast_byte(8'h10);
      fast_byte(8'h3C);
      fast_byte(8'h60);
      if (k == 253) check("sat_254", bus.err_cnt, 254);
      if (k == 254) check("sat_255", bus.err_cnt, 255);
    end
    check("sat_ack_spacing", cyc - c0, 2399);
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    settle();
    check("sat_err", bus.err_cnt, 255);
    check("sat_nack", ack_cnt - a0, 1200);
    check("sat_nstb", stb_cnt - s0, 0);
    check("no_back_to_back", b2b_viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the number of baud_clk cycles allowed between bytes inside a frame.
REQ-002 SHALL have parameter SYNC, default 8'h55, meaning the frame start byte.
REQ-003 baud_clk  input  1  single clock, the same x4 baud clock as the upstream receiver; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  received byte from the upstream UART receiver.
REQ-006 rx_rdy  input  1  rx_data valid; held until acknowledged.
REQ-007 rx_ack  output  1  registered one-cycle byte-consumed pulse.
REQ-008 wr_stb  output  1  registered one-cycle register-write strobe.
REQ-009 wr_addr  output  8  write address, valid while wr_stb is high and held afterwards.
REQ-010 wr_data  output  8  write data, valid while wr_stb is high and held afterwards.
REQ-011 err_cnt  output  8  saturating count of bad checksums plus timeouts.

Function
REQ-012 Frame format SHALL be SYNC, ADDR, DATA, CSUM, where a frame is valid iff (SYNC+ADDR+DATA+CSUM) mod 256 == 0.
REQ-013 A byte SHALL be consumed in a cycle where rx_rdy=1 and rx_ack=0; rx_ack SHALL be 1 in the following cycle only.
REQ-014 The block SHALL never consume a byte in a cycle where rx_ack=1, because the upstream rx_rdy falls one cycle after the ack.
REQ-015 States SHALL be IDLE, ADDR, DATA, CSUM.
REQ-016 Transitions:
- IDLE->ADDR on a consumed byte equal to SYNC; other bytes are discarded with no error.
- ADDR->DATA and DATA->CSUM on a consumed byte, which is latched into a holding register.
- CSUM->IDLE on a consumed byte.
REQ-017 Valid CSUM:
- wr_stb=1 in the cycle after CSUM is consumed (latency 1).
- wr_addr/wr_data SHALL update in that same cycle.
REQ-018 Invalid CSUM SHALL produce no wr_stb, increment err_cnt by 1, and return the state to IDLE.
REQ-019 Checksum arithmetic SHALL be an 8-bit running sum with wrap-around; carries are discarded.
REQ-020 Timeout counter:
- Runs in ADDR, DATA and CSUM; clears on every consumed byte and on entry to IDLE.
- On reaching TIMEOUT-1 with no byte consumed: state->IDLE, err_cnt+1, partial frame dropped.
REQ-021 Timeout and byte consumption in the same cycle SHALL resolve as consumption; the timeout SHALL NOT fire.
REQ-022 err_cnt SHALL saturate at 255 and never wrap.
REQ-023 A SYNC byte received in ADDR, DATA or CSUM SHALL be treated as ordinary frame data; no resync occurs mid-frame.
REQ-024 wr_stb SHALL never be high in two consecutive cycles.

Reset
REQ-025 On rst_n=0, independent of clock:
- state=IDLE; rx_ack=0; wr_stb=0; wr_addr=0; wr_data=0; err_cnt=0.
- timeout counter=0; holding registers=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first byte after release SHALL be hunted for SYNC.
REQ-027 Outputs SHALL be driven only from registers.

Structure
REQ-028 The shared package SHALL hold the state enum (IDLE/ADDR/DATA/CSUM) and the SYNC default constant.
REQ-029 The timeout counter width SHALL be $clog2(TIMEOUT), computed locally.
REQ-030 The block SHALL be a single module with no sub-module; the checksum and timer are inline.

Verification
REQ-031 Bytes 55 10 3C 5F -> one wr_stb with wr_addr=10, wr_data=3C; err_cnt=0; exactly four rx_ack pulses.
REQ-032 Bytes 55 10 3C 60 -> no wr_stb; err_cnt=1; a following frame 55 01 02 A8 -> wr_stb with addr 01, data 02.
REQ-033 Bytes 00 FF 55 10 3C 5F -> bytes 00 and FF acked and discarded; exactly one write (10/3C); err_cnt=0.
REQ-034 Bytes 55 10, then TIMEOUT idle cycles -> err_cnt=1, state IDLE; next frame 55 10 3C 5F is accepted.
REQ-035 rst_n pulsed low after 55 10 -> all outputs zero; 3C 5F then discarded; a later full frame is accepted.
REQ-036 300 bad-checksum frames -> err_cnt=255 with no wrap; rx_rdy held high continuously -> ack every second cycle, never back-to-back.
